// File: rtl/inst_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : inst_rom_arbiter
// Description : Shares one combinational instruction ROM between instruction
//               fetch and a data-side constant-table read port.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_rom_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              stallreq_if,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data
);

  localparam logic [3:0] c_max_burst = 4'(MAX_BURST);

  logic [3:0]        r_burst_cnt;
  logic [3:0]        w_burst_nxt;
  logic              w_fetch_forced;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_misaligned;

  // Fetch overrides the default data priority only once data has had its burst.
  assign w_fetch_forced = i_req && (r_burst_cnt == c_max_burst);
  assign d_gnt          = d_req && !w_fetch_forced;
  assign i_gnt          = i_req && !d_gnt;
  assign stallreq_if    = i_req && !i_gnt;

  assign w_sel_addr   = d_gnt ? d_addr : (i_gnt ? i_addr : '0);
  assign w_misaligned = |w_sel_addr[1:0];
  assign rom_addr     = w_sel_addr;
  assign rom_ce       = (d_gnt || i_gnt) && !w_misaligned;

  always_comb begin
    w_burst_nxt = r_burst_cnt;
    if (!i_req || i_gnt) begin
      w_burst_nxt = 4'd0;
    end else if (d_gnt && (r_burst_cnt < c_max_burst)) begin
      w_burst_nxt = r_burst_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_burst_cnt <= 4'd0;
      i_rvalid    <= 1'b0;
      i_rdata     <= '0;
      i_err       <= 1'b0;
      d_rvalid    <= 1'b0;
      d_rdata     <= '0;
      d_err       <= 1'b0;
    end else begin
      r_burst_cnt <= w_burst_nxt;
      i_rvalid    <= i_gnt;
      d_rvalid    <= d_gnt;
      // Only the winning port's response registers update; the loser holds.
      if (i_gnt) begin
        i_rdata <= w_misaligned ? '0 : rom_data;
        i_err   <= w_misaligned;
      end
      if (d_gnt) begin
        d_rdata <= w_misaligned ? '0 : rom_data;
        d_err   <= w_misaligned;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_rom_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_rom_arbiter
// Description : Directed self-checking bench for inst_rom_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_rom_arbiter;

  logic        clk;
  logic        rst;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_gnt;
  logic        i_rvalid;
  logic [31:0] i_rdata;
  logic        i_err;
  logic        d_req;
  logic [31:0] d_addr;
  logic        d_gnt;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        stallreq_if;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;

  int n_pass  = 0;
  int n_total = 0;

  inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_gnt       (i_gnt),
    .i_rvalid    (i_rvalid),
    .i_rdata     (i_rdata),
    .i_err       (i_err),
    .d_req       (d_req),
    .d_addr      (d_addr),
    .d_gnt       (d_gnt),
    .d_rvalid    (d_rvalid),
    .d_rdata     (d_rdata),
    .d_err       (d_err),
    .stallreq_if (stallreq_if),
    .rom_ce      (rom_ce),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM contents: word 2 is the fetch test word, every other word is C0DE_00xx.
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    logic [5:0] idx;
    idx = a[7:2];
    if (idx == 6'd2) return 32'h3401_0020;
    return 32'hC0DE_0000 | {26'd0, idx};
  endfunction

  assign rom_data = rom_word(rom_addr);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    rst    = 1'b0;
    i_req  = 1'b0;
    i_addr = '0;
    d_req  = 1'b0;
    d_addr = '0;
    tick();
    tick();
    check("rst_i_rvalid", 64'(i_rvalid), 64'd0);
    check("rst_d_rvalid", 64'(d_rvalid), 64'd0);
    check("rst_i_rdata", 64'(i_rdata), 64'd0);
    check("rst_d_rdata", 64'(d_rdata), 64'd0);
    check("rst_burst", 64'(dut.r_burst_cnt), 64'd0);
    check("idle_rom_ce", 64'(rom_ce), 64'd0);
    rst = 1'b1;
    tick();

    // Single fetch
    i_req = 1'b1; i_addr = 32'h8;
    #1;
    check("sf_i_gnt", 64'(i_gnt), 64'd1);
    check("sf_rom_ce", 64'(rom_ce), 64'd1);
    check("sf_rom_addr", 64'(rom_addr), 64'h8);
    check("sf_stall", 64'(stallreq_if), 64'd0);
    tick();
    i_req = 1'b0;
    check("sf_i_rvalid", 64'(i_rvalid), 64'd1);
    check("sf_i_rdata", 64'(i_rdata), 64'h3401_0020);
    check("sf_i_err", 64'(i_err), 64'd0);

    // Conflict: data wins by default
    i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_addr = 32'h10;
    #1;
    check("cf_d_gnt", 64'(d_gnt), 64'd1);
    check("cf_i_gnt", 64'(i_gnt), 64'd0);
    check("cf_stall", 64'(stallreq_if), 64'd1);
    check("cf_rom_addr", 64'(rom_addr), 64'h10);
    tick();
    i_req = 1'b0; d_req = 1'b0;
    check("cf_d_rvalid", 64'(d_rvalid), 64'd1);
    check("cf_d_rdata", 64'(d_rdata), 64'hC0DE_0004);
    check("cf_i_rvalid", 64'(i_rvalid), 64'd0);
    check("cf_i_rdata_hold", 64'(i_rdata), 64'h3401_0020);
    tick();
    check("cf_burst_clear", 64'(dut.r_burst_cnt), 64'd0);

    // Starvation limit: D,D,D,D,I,D,D,D,D,I
    i_req = 1'b1; i_addr = 32'hC; d_req = 1'b1; d_addr = 32'h20;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      check($sformatf("sv_i_gnt_%0d", k), 64'(i_gnt), (k == 4 || k == 9) ? 64'd1 : 64'd0);
      check($sformatf("sv_d_gnt_%0d", k), 64'(d_gnt), (k == 4 || k == 9) ? 64'd0 : 64'd1);
      tick();
      if (i_rvalid) begin
        pulses++;
        check("sv_i_rdata", 64'(i_rdata), 64'hC0DE_0003);
      end
    end
    check("sv_pulses", 64'(pulses), 64'd2);
    i_req = 1'b0; d_req = 1'b0;
    tick();

    // Misaligned data access
    d_req = 1'b1; d_addr = 32'h6;
    #1;
    check("ma_d_gnt", 64'(d_gnt), 64'd1);
    check("ma_rom_ce", 64'(rom_ce), 64'd0);
    tick();
    d_req = 1'b0;
    check("ma_d_rvalid", 64'(d_rvalid), 64'd1);
    check("ma_d_err", 64'(d_err), 64'd1);
    check("ma_d_rdata", 64'(d_rdata), 64'd0);
    check("ma_i_err", 64'(i_err), 64'd0);
    tick();
    check("ma_d_rvalid_1cyc", 64'(d_rvalid), 64'd0);

    // Streaming fetch of words 0..7
    i_req = 1'b1;
    for (int k = 0; k < 8; k++) begin
      i_addr = 32'(4 * k);
      tick();
      check($sformatf("st_i_rvalid_%0d", k), 64'(i_rvalid), 64'd1);
      check($sformatf("st_i_rdata_%0d", k), 64'(i_rdata),
            (k == 2) ? 64'h3401_0020 : (64'hC0DE_0000 | 64'(k)));
    end
    i_req = 1'b0;
    tick();
    check("idle_i_rvalid", 64'(i_rvalid), 64'd0);
    check("idle_i_rdata_hold", 64'(i_rdata), 64'hC0DE_0007);

    // Asynchronous reset mid-access
    d_req = 1'b1; d_addr = 32'h10;
    #2;
    rst = 1'b0;
    #1;
    check("ar_d_rvalid", 64'(d_rvalid), 64'd0);
    check("ar_i_rdata", 64'(i_rdata), 64'd0);
    check("ar_d_err", 64'(d_err), 64'd0);
    check("ar_burst", 64'(dut.r_burst_cnt), 64'd0);
    d_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check("ar_post_d_rvalid", 64'(d_rvalid), 64'd0);
    check("ar_post_i_rvalid", 64'(i_rvalid), 64'd0);
    check("ar_post_d_rdata", 64'(d_rdata), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_rom_arbiter.md
# inst_rom_arbiter

Two-port arbiter that shares the single combinational instruction ROM between the instruction-fetch stage and a data-side read port used for constant tables held in ROM. It grants at most one ROM access per cycle, drives the ROM chip-enable and address, and returns the ROM word to the winning requester through a registered response. It sits between the `pc_reg`/IF logic, the MEM stage and `inst_rom`.

## Interface
- `ADDR_W`, 32, byte address width of both request ports and `rom_addr`.
- `DATA_W`, 32, ROM word width.
- `MAX_BURST`, 4, maximum consecutive data-port grants while fetch is waiting. Legal range is 1–15.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request. Held together with `i_addr` until granted.
- `i_addr`  in  ADDR_W  fetch byte address.
- `i_gnt`  out  1  fetch request accepted this cycle (combinational).
- `i_rvalid`  out  1  fetch response valid (registered).
- `i_rdata`  out  DATA_W  fetch response word. Held until the next `i_rvalid`.
- `i_err`  out  1  fetch response carries a misaligned-address error. Qualified by `i_rvalid`.
- `d_req`, `d_addr`, `d_gnt`, `d_rvalid`, `d_rdata`, `d_err`: the same signals for the data port.
- `stallreq_if`  out  1  equals `i_req & ~i_gnt`. Goes to the pipeline control block.
- `rom_ce`  out  1  ROM chip enable (combinational).
- `rom_addr`  out  ADDR_W  ROM byte address (combinational).
- `rom_data`  in  DATA_W  ROM read word (combinational from `rom_addr`).

## Operation
- **Arbitration** (combinational, every cycle):
  - The data port has default priority.
  - Exception: fetch wins when `i_req` is high and `burst_cnt == MAX_BURST`.
  - Only `d_req` high: data granted. Only `i_req` high: fetch granted. Neither high: no grant.
- **burst_cnt** (4-bit register):
  - Increments on each data grant made while `i_req` is high, saturating at `MAX_BURST`.
  - Clears on any fetch grant, and on any cycle where `i_req` is low.
- **ROM drive:**
  - On a granted cycle, `rom_addr` = granted address and `rom_ce` = 1, unless that address is misaligned.
  - Misaligned means `addr[1:0] != 0`. Then `rom_ce` = 0.
  - No grant: `rom_ce` = 0 and `rom_addr` = 0.
- **Response capture** (rising edge after a grant):
  - The granted port's `rvalid` is set to 1 for exactly one cycle.
  - `rdata` ← `rom_data`. For a misaligned address, `rdata` ← 0 and `err` ← 1.
  - The other port's `rdata` and `err` are unchanged.
- **Request rules:**
  - A requester must keep `req` and `addr` stable until it sees `gnt`.
  - A `gnt` consumes the request. If `req` is still high next cycle, that is a new access.
  - The arbiter does not check address stability.
- **Reset:**
  - Asynchronous assertion clears `burst_cnt` and all registered outputs: `rvalid` = 0, `rdata` = 0, `err` = 0.
  - An access granted in the cycle that reset asserts produces no response.
  - After deassertion, the first edge with a request behaves as from idle.

## Timing
- **Same-cycle paths:** `gnt`, `rom_ce`, `rom_addr` and `stallreq_if` are valid in the same cycle as `req`. The path is req → mux → ROM → capture register.
- **Latency:** `rvalid` and `rdata` appear 1 cycle after `gnt`.
- **Throughput:** one access per cycle across both ports. Back-to-back grants to the same port give back-to-back `rvalid`.
- **Worst-case fetch wait** with `d_req` held high continuously: `MAX_BURST` cycles, then 1 fetch grant.
  - Pattern with default `MAX_BURST` = 4: D,D,D,D,I, repeating.
- **Idle:** with no requests, all `rvalid` are 0 and `rdata` holds its last value.

## Test plan
- **Reset:**
  - Drive `rst` = 0 mid-access with `d_req` = 1.
  - Required: all `rvalid`, `rdata`, `err` = 0 and `burst_cnt` = 0 immediately (asynchronously).
  - Required: no response after release.
- **Single fetch:**
  - Stimulus: `i_req` = 1, `i_addr` = 0x8, `d_req` = 0, ROM word 2 = 0x3401_0020.
  - Required in the same cycle: `i_gnt` = 1, `rom_ce` = 1, `rom_addr` = 0x8, `stallreq_if` = 0.
  - Required next cycle: `i_rvalid` = 1, `i_rdata` = 0x3401_0020, `i_err` = 0.
- **Conflict:**
  - Stimulus: `i_req` and `d_req` both 1 in the same cycle (`i_addr` = 0x0, `d_addr` = 0x10).
  - Required: `d_gnt` = 1, `i_gnt` = 0, `stallreq_if` = 1.
  - Required next cycle: `d_rvalid` = 1 with the word at 0x10, and `i_rdata` unchanged.
- **Starvation limit:**
  - Stimulus: both requests held high for 10 cycles, `MAX_BURST` = 4.
  - Required grant sequence: D,D,D,D,I,D,D,D,D,I.
  - Required: exactly 2 `i_rvalid` pulses.
- **Misaligned:**
  - Stimulus: `d_req` = 1, `d_addr` = 0x6.
  - Required: `d_gnt` = 1 and `rom_ce` = 0.
  - Required next cycle: `d_rvalid` = 1, `d_err` = 1, `d_rdata` = 0.
- **Streaming fetch:**
  - Stimulus: `i_req` held high with `i_addr` stepping by 4 from 0x0 through 0x1C, and `d_req` = 0.
  - Required: 8 consecutive `i_rvalid` cycles carrying ROM words 0–7, in order.
